// File: rtl/io_pkg.sv
// Shared types for the front-panel input logic: debounce FSM states and key indices.
// No logic; imported by debounce and input_logic.
package io_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_PRESS,
        PRESSED,
        WAIT_RELEASE
    } db_state_t;

    localparam int KEY_ENTER = 0;
    localparam int KEY_PEEK  = 1;

endpackage

// File: rtl/debounce.sv
// Synchronizes one active-low pushbutton and debounces it; press pulses once on entry to PRESSED.
// Latency: SYNC_STAGES + DB_CYCLES + 1 cycles from raw edge to press; no backpressure, free-running.
module debounce
    import io_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DB_CYCLES   = 500000
) (
    input  logic Clock,
    input  logic Reset,
    input  logic KEYb_raw,
    output logic level,
    output logic press
);

    localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync;
    logic                   ks;
    db_state_t              state;
    logic [CW-1:0]          cnt;

    assign ks = sync[SYNC_STAGES-1];

    // level is updated alongside the state so it always equals (state is PRESSED or WAIT_RELEASE).
    always_ff @(posedge Clock) begin
        if (Reset) begin
            sync  <= '1;
            state <= IDLE;
            cnt   <= '0;
            level <= 1'b0;
            press <= 1'b0;
        end else begin
            sync  <= {sync[SYNC_STAGES-2:0], KEYb_raw};
            press <= 1'b0;
            case (state)
                IDLE: begin
                    if (!ks) begin
                        state <= WAIT_PRESS;
                        cnt   <= '0;
                    end
                end
                WAIT_PRESS: begin
                    if (ks) begin
                        state <= IDLE;
                    end else if (cnt == CNT_LAST) begin
                        state <= PRESSED;
                        press <= 1'b1;
                        level <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                PRESSED: begin
                    if (ks) begin
                        state <= WAIT_RELEASE;
                        cnt   <= '0;
                    end
                end
                WAIT_RELEASE: begin
                    if (!ks) begin
                        state <= PRESSED;
                    end else if (cnt == CNT_LAST) begin
                        state <= IDLE;
                        level <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/input_logic.sv
// Front-panel inputs: synchronized switches, debounced Enter strobe with DIN capture, debounced PEEKb.
// Latency: ENTER/PEEKb one cycle after the debouncer decision; no backpressure, ENTER is a one-shot.
module input_logic
    import io_pkg::*;
#(
    parameter int WIDTH       = 10,
    parameter int SYNC_STAGES = 2,
    parameter int DB_CYCLES   = 500000
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [WIDTH-1:0] SW,
    input  logic [1:0]       KEYb,
    output logic [WIDTH-1:0] DIN,
    output logic             ENTER,
    output logic             PEEKb
);

    logic [WIDTH-1:0] sw_sync [SYNC_STAGES];
    logic             enter_level;
    logic             enter_press;
    logic             peek_level;
    logic             peek_press;
    logic             unused_ok;

    debounce #(
        .SYNC_STAGES (SYNC_STAGES),
        .DB_CYCLES   (DB_CYCLES)
    ) u_db_enter (
        .Clock    (Clock),
        .Reset    (Reset),
        .KEYb_raw (KEYb[KEY_ENTER]),
        .level    (enter_level),
        .press    (enter_press)
    );

    debounce #(
        .SYNC_STAGES (SYNC_STAGES),
        .DB_CYCLES   (DB_CYCLES)
    ) u_db_peek (
        .Clock    (Clock),
        .Reset    (Reset),
        .KEYb_raw (KEYb[KEY_PEEK]),
        .level    (peek_level),
        .press    (peek_press)
    );

    // Enter only needs its edge and Peek only its level.
    assign unused_ok = &{1'b0, enter_level, peek_press};

    always_ff @(posedge Clock) begin
        if (Reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) sw_sync[i] <= '0;
            DIN   <= '0;
            ENTER <= 1'b0;
            PEEKb <= 1'b1;
        end else begin
            sw_sync[0] <= SW;
            for (int i = 1; i < SYNC_STAGES; i++) sw_sync[i] <= sw_sync[i-1];
            ENTER <= enter_press;
            PEEKb <= ~peek_level;
            if (enter_press) DIN <= sw_sync[SYNC_STAGES-1];
        end
    end

endmodule

// File: tb/tb_input_logic.sv
// Randomized + directed bench for input_logic with a run-length reference model and ENTER/DIN scoreboard.
module tb_input_logic;

    localparam int WIDTH = 10;
    localparam int SYNC  = 2;
    localparam int DB    = 4;

    logic             clk;
    logic             Reset;
    logic [WIDTH-1:0] SW;
    logic [1:0]       KEYb;
    logic [WIDTH-1:0] DIN;
    logic             ENTER;
    logic             PEEKb;

    input_logic #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC), .DB_CYCLES(DB)) dut (
        .Clock (clk),
        .Reset (Reset),
        .SW    (SW),
        .KEYb  (KEYb),
        .DIN   (DIN),
        .ENTER (ENTER),
        .PEEKb (PEEKb)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int               cyc;
        logic [WIDTH-1:0] din;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_fail   = 0;
    int edge_cnt = 0;

    // Reference model: a key flips its accepted state after DB+1 consecutive
    // synchronized samples disagreeing with it; outputs follow one cycle later.
    logic             key_q [2][$];
    logic [WIDTH-1:0] sw_q[$];
    int               run [2];
    logic             acc [2];
    logic             pend;
    logic [WIDTH-1:0] exp_din;
    logic             exp_peekb;

    always @(posedge clk) begin
        edge_cnt++;
        if (Reset) begin
            for (int k = 0; k < 2; k++) begin
                key_q[k].delete();
                for (int s = 0; s < SYNC; s++) key_q[k].push_back(1'b1);
                run[k] = 0;
                acc[k] = 1'b0;
            end
            sw_q.delete();
            for (int s = 0; s < SYNC; s++) sw_q.push_back('0);
            pend      = 1'b0;
            exp_din   = '0;
            exp_peekb = 1'b1;
        end else begin
            exp_peekb = !acc[1];
            if (pend) begin
                sb.push_back('{cyc: edge_cnt, din: sw_q[0]});
                exp_din = sw_q[0];
                pend    = 1'b0;
            end
            for (int k = 0; k < 2; k++) begin
                if ((key_q[k][0] == 1'b0) != acc[k]) begin
                    run[k]++;
                    if (run[k] == DB + 1) begin
                        acc[k] = !acc[k];
                        run[k] = 0;
                        if (k == 0 && acc[0]) pend = 1'b1;
                    end
                end else begin
                    run[k] = 0;
                end
                void'(key_q[k].pop_front());
                key_q[k].push_back(KEYb[k]);
            end
            void'(sw_q.pop_front());
            sw_q.push_back(SW);
        end
    end

    // Monitor: registered outputs sampled mid-cycle.
    always @(negedge clk) begin
        if (edge_cnt > 0) begin
            n_checks++;
            if (PEEKb !== exp_peekb) begin
                n_fail++;
                $display("FAIL peekb cyc=%0d got=%b exp=%b", edge_cnt, PEEKb, exp_peekb);
            end
            n_checks++;
            if (DIN !== exp_din) begin
                n_fail++;
                $display("FAIL din_hold cyc=%0d got=%h exp=%h", edge_cnt, DIN, exp_din);
            end
            if (ENTER === 1'b1) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL enter_unexpected cyc=%0d got=1 exp=0", edge_cnt);
                end else begin
                    if (sb[0].cyc != edge_cnt || DIN !== sb[0].din) begin
                        n_fail++;
                        $display("FAIL enter_pulse cyc=%0d din=%h exp_cyc=%0d exp_din=%h",
                                 edge_cnt, DIN, sb[0].cyc, sb[0].din);
                    end
                    void'(sb.pop_front());
                end
            end else if (sb.size() > 0 && sb[0].cyc <= edge_cnt) begin
                n_checks++;
                n_fail++;
                $display("FAIL enter_missing cyc=%0d got=%b exp_cyc=%0d", edge_cnt, ENTER, sb[0].cyc);
                void'(sb.pop_front());
            end
        end
    end

    task automatic drive(input logic r, input logic [WIDTH-1:0] s, input logic [1:0] k, input int n);
        repeat (n) begin
            @(negedge clk);
            Reset = r;
            SW    = s;
            KEYb  = k;
        end
    endtask

    initial begin
        Reset = 1'b1;
        SW    = 10'h3FF;
        KEYb  = 2'b00;
        drive(1'b1, 10'h3FF, 2'b00, 3);
        drive(1'b0, 10'h3FF, 2'b11, 10);
        // Clean Enter press and release
        drive(1'b0, 10'h2A5, 2'b10, 20);
        drive(1'b0, 10'h2A5, 2'b11, 15);
        // Bouncing Enter, then stable
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 10'h2A5, 2'b10, 2);
            drive(1'b0, 10'h2A5, 2'b11, 2);
        end
        drive(1'b0, 10'h2A5, 2'b10, 15);
        drive(1'b0, 10'h2A5, 2'b11, 15);
        // Peek with a short release glitch
        drive(1'b0, 10'h2A5, 2'b01, 10);
        drive(1'b0, 10'h2A5, 2'b11, 3);
        drive(1'b0, 10'h2A5, 2'b01, 10);
        drive(1'b0, 10'h2A5, 2'b11, 15);
        // Switch changes without Enter
        drive(1'b0, 10'h155, 2'b11, 50);
        // Reset during WAIT_PRESS with Enter held
        drive(1'b0, 10'h0F0, 2'b10, 3);
        drive(1'b1, 10'h0F0, 2'b10, 2);
        drive(1'b0, 10'h0F0, 2'b10, 15);
        drive(1'b0, 10'h0F0, 2'b11, 15);
        // Both keys together
        drive(1'b0, 10'h33C, 2'b00, 12);
        drive(1'b0, 10'h33C, 2'b11, 12);
        // Random segments with occasional reset
        for (int seg = 0; seg < 400; seg++) begin
            logic [1:0] k;
            logic       r;
            int         len;
            k   = 2'($urandom_range(0, 3));
            r   = ($urandom_range(0, 99) < 2);
            len = $urandom_range(1, 10);
            for (int c = 0; c < len; c++) drive(r, 10'($urandom), k, 1);
        end
        drive(1'b0, 10'h000, 2'b11, 20);
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain got=%0d pending exp=0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
